// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared definitions for the pipeline hazard controller:
//   - FSM state encoding (ST_RUN / ST_LU_STALL / ST_FREEZE)
//   - REG_X0, the hard-wired zero register index
//   - pipe_ctrl_t, the bundle of pipeline write enables / flushes, plus the
//     canned bundles FREEZE, BUBBLE, FLUSH, NORMAL and the in-reset bundle.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_FREEZE   = 2'd2
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_flush;
        logic exmem_we;
        logic memwb_we;
    } pipe_ctrl_t;

    // Field order: pc_we ifid_we ifid_flush idex_we idex_flush exmem_we memwb_we
    localparam pipe_ctrl_t FREEZE     = 7'b000_0000; // nothing moves, nothing lost
    localparam pipe_ctrl_t BUBBLE     = 7'b000_1111; // hold PC/IFID, inject bubble into EX
    localparam pipe_ctrl_t FLUSH      = 7'b111_1111; // redirect: squash IF/ID and ID/EX
    localparam pipe_ctrl_t NORMAL     = 7'b110_1011; // everything advances
    localparam pipe_ctrl_t CTRL_RESET = 7'b001_0100; // held in reset: no writes, both flushed

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect
//   Purely combinational load-use hazard compare.
//   Ports:
//     id_rs1/id_rs2         in  source registers of the instruction in ID
//     id_use_rs1/id_use_rs2 in  ID instruction actually reads that source
//     idex_rd               in  destination of the instruction in EX
//     idex_memread          in  instruction in EX is a load
//     load_use              out ID needs the load result before it exists
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] idex_rd,
    input  logic       idex_memread,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_use_rs1 && (id_rs1 == idex_rd);
    assign rs2_hit  = id_use_rs2 && (id_rs2 == idex_rd);
    // A load to x0 produces nothing, so it can never be a hazard.
    assign load_use = idex_memread && (idex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline sequencer for the 5-stage RV32 core. Detects load-use hazards and
//   inserts bubbles, freezes the whole pipe on I/D-cache stalls, squashes
//   IF/ID + ID/EX on a taken branch from EX. Hazard response is combinational;
//   state only tracks multi-cycle bubbles and freezes.
//   Parameters: LOAD_USE_CYCLES (1..3), STALL_TIMEOUT (0 = no watchdog), CNT_W.
//   Ports:
//     clk, rst                          clock, async active-high reset
//     id_rs1/id_rs2/id_use_rs1/id_use_rs2, idex_rd, idex_memread   hazard inputs
//     ex_branch_taken                   EX redirect
//     icache_stall, dcache_stall        memory not ready
//     pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we
//                                       pipeline register controls
//     state_o                           current FSM state (debug)
//     stall_timeout                     sticky freeze watchdog flag
//   Optional feature macro HAZARD_PERF_CNT_EN adds cnt_lu, cnt_freeze,
//   cnt_flush [CNT_W-1:0] performance counters (bubble/freeze/flush cycles).
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int STALL_TIMEOUT   = 1024,
    parameter int CNT_W           = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] idex_rd,
    input  logic       idex_memread,
    input  logic       ex_branch_taken,
    input  logic       icache_stall,
    input  logic       dcache_stall,
    output logic       pc_we,
    output logic       ifid_we,
    output logic       ifid_flush,
    output logic       idex_we,
    output logic       idex_flush,
    output logic       exmem_we,
    output logic       memwb_we,
    output logic [1:0] state_o,
    output logic       stall_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_lu,
    output logic [CNT_W-1:0] cnt_freeze,
    output logic [CNT_W-1:0] cnt_flush
`endif
);

    localparam int WD_W = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_MAX = (STALL_TIMEOUT > 0) ? WD_W'(STALL_TIMEOUT - 1) : '0;
    localparam logic [1:0] LU_INIT = 2'(LOAD_USE_CYCLES - 1);

    state_t            state_q, state_d;
    state_t            ret_state_q, ret_state_d;
    logic [1:0]        lu_cnt_q, lu_cnt_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              stall_timeout_q, stall_timeout_d;

    logic       load_use;
    logic       mem_stall;
    state_t     eff_state;
    pipe_ctrl_t ctrl;
    pipe_ctrl_t ctrl_o;
    logic       is_bubble;
    logic       is_flush;

    hazard_detect u_detect (
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .idex_rd      (idex_rd),
        .idex_memread (idex_memread),
        .load_use     (load_use)
    );

    assign mem_stall = icache_stall | dcache_stall;
    // In FREEZE the pipe resumes with the rules of the state it froze from,
    // in the very cycle the stall drops.
    assign eff_state = (state_q == ST_FREEZE) ? ret_state_q : state_q;

    always_comb begin
        state_d         = state_q;
        ret_state_d     = ST_RUN;
        lu_cnt_d        = lu_cnt_q;
        ctrl            = NORMAL;
        is_bubble       = 1'b0;
        is_flush        = 1'b0;
        if (mem_stall) begin
            ctrl        = FREEZE;
            state_d     = ST_FREEZE;
            ret_state_d = eff_state;   // lu_cnt held across the freeze
        end else if (ex_branch_taken) begin
            // Redirect kills the consumer, so pending bubbles are moot.
            ctrl     = FLUSH;
            is_flush = 1'b1;
            state_d  = ST_RUN;
            lu_cnt_d = 2'd0;
        end else if (eff_state == ST_LU_STALL) begin
            ctrl      = BUBBLE;
            is_bubble = 1'b1;
            lu_cnt_d  = lu_cnt_q - 2'd1;
            state_d   = (lu_cnt_q == 2'd1) ? ST_RUN : ST_LU_STALL;
        end else if (load_use) begin
            ctrl      = BUBBLE;
            is_bubble = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
                state_d  = ST_LU_STALL;
                lu_cnt_d = LU_INIT;
            end else begin
                state_d  = ST_RUN;
            end
        end else begin
            ctrl    = NORMAL;
            state_d = ST_RUN;
        end

        // Watchdog counts consecutive frozen cycles, saturating.
        if (mem_stall) begin
            wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
        end else begin
            wd_cnt_d = '0;
        end
        stall_timeout_d = stall_timeout_q |
                          ((STALL_TIMEOUT != 0) && mem_stall && (wd_cnt_q == WD_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_RUN;
            ret_state_q     <= ST_RUN;
            lu_cnt_q        <= 2'd0;
            wd_cnt_q        <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ret_state_q     <= ret_state_d;
            lu_cnt_q        <= lu_cnt_d;
            wd_cnt_q        <= wd_cnt_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    // Reset overrides the controls combinationally so nothing is written while held.
    assign ctrl_o        = rst ? CTRL_RESET : ctrl;
    assign state_o       = rst ? 2'd0 : state_q;
    assign stall_timeout = stall_timeout_q;

    assign pc_we      = ctrl_o.pc_we;
    assign ifid_we    = ctrl_o.ifid_we;
    assign ifid_flush = ctrl_o.ifid_flush;
    assign idex_we    = ctrl_o.idex_we;
    assign idex_flush = ctrl_o.idex_flush;
    assign exmem_we   = ctrl_o.exmem_we;
    assign memwb_we   = ctrl_o.memwb_we;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_lu_q, cnt_lu_d;
    logic [CNT_W-1:0] cnt_freeze_q, cnt_freeze_d;
    logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;

    always_comb begin
        cnt_lu_d     = cnt_lu_q     + CNT_W'(is_bubble);
        cnt_freeze_d = cnt_freeze_q + CNT_W'(mem_stall);
        cnt_flush_d  = cnt_flush_q  + CNT_W'(is_flush);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_lu_q     <= '0;
            cnt_freeze_q <= '0;
            cnt_flush_q  <= '0;
        end else begin
            cnt_lu_q     <= cnt_lu_d;
            cnt_freeze_q <= cnt_freeze_d;
            cnt_flush_q  <= cnt_flush_d;
        end
    end

    assign cnt_lu     = cnt_lu_q;
    assign cnt_freeze = cnt_freeze_q;
    assign cnt_flush  = cnt_flush_q;
`else
    logic unused_flags;
    assign unused_flags = is_bubble ^ is_flush;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller
//   Directed test of hazard_controller. Two instances share one stimulus:
//   u_dut1 with LOAD_USE_CYCLES=1 and u_dut2 with LOAD_USE_CYCLES=2, both with
//   STALL_TIMEOUT=8. Inputs change on the falling edge; outputs are checked
//   1 time unit later, before the next rising edge commits the cycle.
//   Control bundle order: {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we}.
module tb_hazard_controller;

    localparam logic [6:0] C_FREEZE = 7'b000_0000;
    localparam logic [6:0] C_BUBBLE = 7'b000_1111;
    localparam logic [6:0] C_FLUSH  = 7'b111_1111;
    localparam logic [6:0] C_NORMAL = 7'b110_1011;
    localparam logic [6:0] C_RESET  = 7'b001_0100;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, idex_rd;
    logic       id_use_rs1, id_use_rs2, idex_memread;
    logic       ex_branch_taken, icache_stall, dcache_stall;

    logic       pc_we1, ifid_we1, ifid_flush1, idex_we1, idex_flush1, exmem_we1, memwb_we1;
    logic       pc_we2, ifid_we2, ifid_flush2, idex_we2, idex_flush2, exmem_we2, memwb_we2;
    logic [1:0] state1, state2;
    logic       to1, to2;
    logic [6:0] c1, c2;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign c1 = {pc_we1, ifid_we1, ifid_flush1, idex_we1, idex_flush1, exmem_we1, memwb_we1};
    assign c2 = {pc_we2, ifid_we2, ifid_flush2, idex_we2, idex_flush2, exmem_we2, memwb_we2};

    hazard_controller #(.LOAD_USE_CYCLES(1), .STALL_TIMEOUT(8), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .idex_rd(idex_rd), .idex_memread(idex_memread), .ex_branch_taken(ex_branch_taken),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .pc_we(pc_we1), .ifid_we(ifid_we1), .ifid_flush(ifid_flush1), .idex_we(idex_we1),
        .idex_flush(idex_flush1), .exmem_we(exmem_we1), .memwb_we(memwb_we1),
        .state_o(state1), .stall_timeout(to1)
`ifdef HAZARD_PERF_CNT_EN
        , .cnt_lu(), .cnt_freeze(), .cnt_flush()
`endif
    );

    hazard_controller #(.LOAD_USE_CYCLES(2), .STALL_TIMEOUT(8), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .idex_rd(idex_rd), .idex_memread(idex_memread), .ex_branch_taken(ex_branch_taken),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .pc_we(pc_we2), .ifid_we(ifid_we2), .ifid_flush(ifid_flush2), .idex_we(idex_we2),
        .idex_flush(idex_flush2), .exmem_we(exmem_we2), .memwb_we(memwb_we2),
        .state_o(state2), .stall_timeout(to2)
`ifdef HAZARD_PERF_CNT_EN
        , .cnt_lu(), .cnt_freeze(), .cnt_flush()
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply one cycle's inputs on the falling edge and let them settle.
    task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic mr,
                         input logic br, input logic ic, input logic dc);
        @(negedge clk);
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        idex_rd = rd; idex_memread = mr; ex_branch_taken = br;
        icache_stall = ic; dcache_stall = dc;
        #1;
    endtask

    task automatic idle();
        drive(5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lu_x5();
        drive(5'd5, 1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        chk("reset_ctrl1", {1'b0, c1}, {1'b0, C_RESET});
        chk("reset_ctrl2", {1'b0, c2}, {1'b0, C_RESET});
        chk("reset_state", {4'd0, state1, state2}, 8'd0);
        chk("reset_timeout", {6'd0, to1, to2}, 8'd0);

        @(negedge clk); rst = 1'b0;
        idle();
        chk("idle_normal1", {1'b0, c1}, {1'b0, C_NORMAL});

        // Load x5 in EX, ID reads x5.
        lu_x5();
        chk("lu1_bubble", {1'b0, c1}, {1'b0, C_BUBBLE});
        chk("lu2_bubble_a", {1'b0, c2}, {1'b0, C_BUBBLE});
        chk("lu2_state_a", {6'd0, state2}, 8'd0);
        idle();
        chk("lu1_after", {1'b0, c1}, {1'b0, C_NORMAL});
        chk("lu2_bubble_b", {1'b0, c2}, {1'b0, C_BUBBLE});
        chk("lu2_state_b", {6'd0, state2}, 8'd1);
        idle();
        chk("lu2_after", {1'b0, c2}, {1'b0, C_NORMAL});
        chk("lu2_state_c", {6'd0, state2}, 8'd0);

        // Load to x0 never hazards.
        drive(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("x0_no_bubble", {1'b0, c1}, {1'b0, C_NORMAL});
        // rs2 matches but is not read.
        drive(5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rs2_unused", {1'b0, c1}, {1'b0, C_NORMAL});
        // rs2 matches and is read.
        drive(5'd3, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rs2_bubble", {1'b0, c1}, {1'b0, C_BUBBLE});
        idle();
        chk("rs2_lu2_second", {1'b0, c2}, {1'b0, C_BUBBLE});
        idle();

        // Branch beats load-use.
        drive(5'd5, 1'b1, 5'd6, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("br_flush1", {1'b0, c1}, {1'b0, C_FLUSH});
        chk("br_flush2", {1'b0, c2}, {1'b0, C_FLUSH});
        idle();
        chk("br_no_bubble2", {1'b0, c2}, {1'b0, C_NORMAL});
        chk("br_state2", {6'd0, state2}, 8'd0);

        // D-cache stall inside LU_STALL.
        lu_x5();
        chk("frz_lu_start", {1'b0, c2}, {1'b0, C_BUBBLE});
        drive(5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("frz_c1_ctrl", {1'b0, c2}, {1'b0, C_FREEZE});
        chk("frz_c1_state", {6'd0, state2}, 8'd1);
        drive(5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("frz_c2_ctrl", {1'b0, c2}, {1'b0, C_FREEZE});
        chk("frz_c2_state", {6'd0, state2}, 8'd2);
        drive(5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("frz_c3_ctrl", {1'b0, c2}, {1'b0, C_FREEZE});
        chk("frz_c3_ctrl1", {1'b0, c1}, {1'b0, C_FREEZE});
        idle();
        chk("frz_resume2", {1'b0, c2}, {1'b0, C_BUBBLE});
        chk("frz_resume1", {1'b0, c1}, {1'b0, C_NORMAL});
        idle();
        chk("frz_run2", {1'b0, c2}, {1'b0, C_NORMAL});
        chk("frz_run_state2", {6'd0, state2}, 8'd0);

        // Seven frozen cycles: just short of the watchdog.
        for (int i = 0; i < 7; i++)
            drive(5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("wd_7_no_timeout", {7'd0, to1}, 8'd0);
        // Eight frozen cycles: sets after the 8th.
        for (int i = 0; i < 8; i++) begin
            drive(5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("wd_during", {7'd0, to1}, 8'd0);
        end
        idle();
        chk("wd_set", {6'd0, to1, to2}, 8'd3);
        chk("wd_resume", {1'b0, c1}, {1'b0, C_NORMAL});
        idle();
        chk("wd_sticky", {7'd0, to1}, 8'd1);

        // Reset in the middle of LU_STALL.
        lu_x5();
        idle();
        chk("rst_pre_state2", {6'd0, state2}, 8'd1);
        @(negedge clk); rst = 1'b1; #1;
        chk("rst_mid_ctrl2", {1'b0, c2}, {1'b0, C_RESET});
        chk("rst_mid_state2", {6'd0, state2}, 8'd0);
        @(negedge clk); rst = 1'b0;
        idle();
        chk("rst_post_ctrl2", {1'b0, c2}, {1'b0, C_NORMAL});
        chk("rst_post_state2", {6'd0, state2}, 8'd0);
        chk("rst_clears_timeout", {7'd0, to1}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
